// File: rtl/charlie_key_scanner.sv
// Charlieplexed 8-line key matrix scanner: drives one line at a time and samples the rest.
// Optional build macro CHARLIE_SCAN_DEBOUNCE_EN adds multi-frame debounce before commit.
module charlie_key_scanner #(
  parameter int unsigned SETTLE_CYCLES    = 4,
  parameter int unsigned DISCHARGE_CYCLES = 2
`ifdef CHARLIE_SCAN_DEBOUNCE_EN
  ,parameter int unsigned DEBOUNCE_FRAMES = 3
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [63:0] key_state,
  output logic        frame_valid,
  output logic        key_changed
);

  // state     | meaning
  // S_IDLE    | lines released, waiting for enable
  // S_DRIVE   | current row line driven high, sample on last cycle
  // S_DISCH   | all lines released so the row node discharges
  // S_COMMIT  | frame complete, publish key frame
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DISCH, S_COMMIT} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DISCH_LOAD  = 4'(DISCHARGE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  row, row_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  sync1, sync2;
  logic [63:0] shadow, shadow_nxt;
  logic [7:0]  drive_nxt;
  logic        abort, commit_go, commit_ok;
  logic [63:0] commit_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      row    <= 3'd0;
      cnt    <= 4'd0;
      sync1  <= 8'd0;
      sync2  <= 8'd0;
      shadow <= 64'd0;
    end else begin
      state  <= state_nxt;
      row    <= row_nxt;
      cnt    <= cnt_nxt;
      sync1  <= uio_in;
      sync2  <= sync1;
      shadow <= shadow_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_DRIVE;
          row_nxt   = 3'd0;
          cnt_nxt   = SETTLE_LOAD;
        end
      end
      S_DRIVE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          row_nxt   = 3'd0;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = S_DISCH;
          cnt_nxt   = DISCH_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DISCH: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          row_nxt   = 3'd0;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          if (row == 3'd7) begin
            state_nxt = S_COMMIT;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = S_DRIVE;
            row_nxt   = row + 3'd1;
            cnt_nxt   = SETTLE_LOAD;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_COMMIT: begin
        row_nxt = 3'd0;
        if (enable) begin
          state_nxt = S_DRIVE;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        row_nxt   = 3'd0;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign abort     = ((state == S_DRIVE) || (state == S_DISCH)) && !enable;
  assign commit_go = (state_nxt == S_COMMIT);

  // The driven line reads back high through itself, so the diagonal is masked off.
  always_comb begin
    shadow_nxt = shadow;
    if (abort) begin
      shadow_nxt = 64'd0;
    end else if ((state == S_DRIVE) && (cnt == 4'd0)) begin
      shadow_nxt[{row, 3'b000} +: 8] = sync2 & ~(8'b1 << row);
    end
  end

`ifdef CHARLIE_SCAN_DEBOUNCE_EN
  localparam logic [3:0] DEB_TH = 4'(DEBOUNCE_FRAMES);

  logic [63:0] candidate, cand_nxt;
  logic [3:0]  stable_cnt, stable_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate  <= 64'd0;
      stable_cnt <= 4'd0;
    end else begin
      candidate  <= cand_nxt;
      stable_cnt <= stable_nxt;
    end
  end

  always_comb begin
    cand_nxt   = candidate;
    stable_nxt = stable_cnt;
    if (abort) begin
      cand_nxt   = 64'd0;
      stable_nxt = 4'd0;
    end else if (commit_go) begin
      if (shadow == candidate) begin
        stable_nxt = (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
      end else begin
        cand_nxt   = shadow;
        stable_nxt = 4'd1;
      end
    end
  end

  assign commit_val = cand_nxt;
  assign commit_ok  = (stable_nxt >= DEB_TH);
`else
  assign commit_val = shadow;
  assign commit_ok  = 1'b1;
`endif

  // Outputs are registered from next-state values so they line up with the state register.
  always_comb begin
    drive_nxt = 8'd0;
    if (state_nxt == S_DRIVE) drive_nxt = 8'b1 << row_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uio_out     <= 8'd0;
      uio_oe      <= 8'd0;
      key_state   <= 64'd0;
      frame_valid <= 1'b0;
      key_changed <= 1'b0;
    end else begin
      uio_out     <= drive_nxt;
      uio_oe      <= drive_nxt;
      frame_valid <= commit_go;
      key_changed <= commit_go && commit_ok && (commit_val != key_state);
      if (commit_go && commit_ok) key_state <= commit_val;
    end
  end

endmodule

// File: tb/tb_charlie_key_scanner.sv
// Directed bench for charlie_key_scanner with a behavioural key-matrix model on uio_in.
module tb_charlie_key_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [63:0] key_state;
  logic        frame_valid;
  logic        key_changed;

  int n_err = 0;
  int n_chk = 0;
  int mode  = 0;

`ifdef CHARLIE_SCAN_DEBOUNCE_EN
  localparam int NF = 3;
`else
  localparam int NF = 1;
`endif

  localparam logic [63:0] KEY_R2C5 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] ALL_KEYS = 64'h7FBF_DFEF_F7FB_FDFE;

  charlie_key_scanner dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .key_state(key_state),
    .frame_valid(frame_valid), .key_changed(key_changed)
  );

  always #5 clk = ~clk;

  // mode 0: no keys, 1: key between row 2 and column 5, 2: every line reads high
  always_comb begin
    uio_in = 8'h00;
    case (mode)
      1: uio_in = (uio_oe == 8'h04) ? 8'h24 : 8'h00;
      2: uio_in = 8'hFF;
      default: uio_in = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_valid && n < 300);
    if (!frame_valid) check("frame_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int fv_seen;
    logic [7:0] e;

    rst_n  = 1'b0;
    enable = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    check("rst_oe",  {56'd0, uio_oe}, 64'd0);
    check("rst_out", {56'd0, uio_out}, 64'd0);
    check("rst_ks",  key_state, 64'd0);
    check("rst_flags", {62'd0, frame_valid, key_changed}, 64'd0);

    // full frame walk with no keys
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      e = 8'h00;
      if (i < 48 && (i % 6) < 4) e = 8'h01 << (i / 6);
      check($sformatf("seq%0d", i), {46'd0, uio_oe, uio_out, frame_valid, key_changed},
            {46'd0, e, e, (i == 48), 1'b0});
    end
    check("idle_frame_ks", key_state, 64'd0);
    @(negedge clk);
    check("wrap_row0", {56'd0, uio_oe}, 64'h01);

    // single key row 2 / col 5
    mode = 1;
    for (int f = 1; f < NF; f++) begin
      wait_frame(n);
      check("key_pending", key_state, 64'd0);
    end
    wait_frame(n);
    check("key_ks", key_state, KEY_R2C5);
    check("key_chg", {63'd0, key_changed}, 64'd1);
    wait_frame(n);
    check("period", n, 64'd49);
    check("key_ks_hold", key_state, KEY_R2C5);
    check("key_nochg", {63'd0, key_changed}, 64'd0);

    // every line high: all keys except the diagonal
    mode = 2;
    for (int f = 1; f < NF; f++) begin
      wait_frame(n);
      check("all_pending", key_state, KEY_R2C5);
    end
    wait_frame(n);
    check("all_ks", key_state, ALL_KEYS);
    check("all_chg", {63'd0, key_changed}, 64'd1);

    // abort during row 4 drive
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uio_oe != 8'h10 && n < 100);
    check("row4_reached", {56'd0, uio_oe}, 64'h10);
    enable = 1'b0;
    @(negedge clk);
    check("abort_oe", {48'd0, uio_oe, uio_out}, 64'd0);
    check("abort_ks", key_state, ALL_KEYS);
    fv_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_valid || uio_oe != 8'h00) fv_seen++;
    end
    check("abort_quiet", fv_seen, 64'd0);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_row0", {56'd0, uio_oe}, 64'h01);
    for (int f = 0; f < NF; f++) begin
      wait_frame(n);
      check("reenable_ks", key_state, ALL_KEYS);
      check("reenable_nochg", {63'd0, key_changed}, 64'd0);
    end

    // asynchronous reset in the middle of a drive phase
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uio_oe == 8'h00 && n < 100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_oe", {48'd0, uio_oe, uio_out}, 64'd0);
    check("arst_ks", key_state, 64'd0);
    @(negedge clk);

`ifdef CHARLIE_SCAN_DEBOUNCE_EN
    // two frames of a bounce must not commit; three stable frames must
    mode   = 1;
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_frame(n);
    check("db_f1", key_state, 64'd0);
    wait_frame(n);
    check("db_f2", key_state, 64'd0);
    mode = 0;
    wait_frame(n);
    check("db_f3", key_state, 64'd0);
    check("db_f3_chg", {63'd0, key_changed}, 64'd0);
    mode = 1;
    wait_frame(n);
    check("db_f4", key_state, 64'd0);
    wait_frame(n);
    check("db_f5", key_state, 64'd0);
    wait_frame(n);
    check("db_f6", key_state, KEY_R2C5);
    check("db_f6_chg", {63'd0, key_changed}, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
